alu_seq_muldiv: RTL and testbench

// - Parametrised successor to the single-cycle 32-bit ALU in the MIPS datapath: same Aluctl encodings plus SRL, SRA, SLTU, XOR, iterative MULTU/DIVU and HI/LO.
// - Sits in EX; the control unit pulses start and stalls the pipe on busy until done.
// - All results are registered. Logic/arith ops take 1 cycle; MULTU/DIVU take WIDTH+1 cycles.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_seq_muldiv_if.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 67 ++++++
 rtl/alu_seq_muldiv.sv | 131 +++++++++++++
 tb/tb_alu_seq_muldiv.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: Aluctl op codes, FSM state codes and op classification.
// Imported by the ALU and by the control unit that drives it.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SRL   = 4'd3;
    localparam logic [3:0] ALU_SRA   = 4'd4;
    localparam logic [3:0] ALU_SLTU  = 4'd5;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_MULTU = 4'd8;
    localparam logic [3:0] ALU_DIVU  = 4'd9;
    localparam logic [3:0] ALU_SLL   = 4'd10;
    localparam logic [3:0] ALU_XOR   = 4'd11;
    localparam logic [3:0] ALU_NOR   = 4'd12;
    localparam logic [3:0] ALU_MFHI  = 4'd13;
    localparam logic [3:0] ALU_MFLO  = 4'd14;
    localparam logic [3:0] ALU_RSVD  = 4'd15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    function automatic logic is_multi_cycle(input logic [3:0] op);
        return (op == ALU_MULTU) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// Request/result bundle between the EX-stage control unit (master) and the ALU (slave).
interface alu_seq_muldiv_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [3:0]         Aluctl;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [SHAMT_W-1:0] shift_amount;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   Aluout;
    logic               zero;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (
        output start, Aluctl, A, B, shift_amount,
        input  busy, done, Aluout, zero, hi, lo
    );

    modport slave (
        input  start, Aluctl, A, B, shift_amount,
        output busy, done, Aluout, zero, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per step.
// acc holds {upper, lower}: product halves for MULTU, {remainder, quotient} for DIVU.
module alu_muldiv_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               last,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opnd_r;
    logic               div_mode_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_rem_sh_s;
    logic [WIDTH:0]     div_diff_s;

    assign last = (cnt_r == SHAMT_W'(WIDTH - 1));

    // Next accumulator value for one multiply or divide step.
    always_comb begin
        mul_sum_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                     + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_rem_sh_s = acc_r[2*WIDTH-1:WIDTH-1];
        div_diff_s   = div_rem_sh_s - {1'b0, opnd_r};
        if (div_mode_r) begin
            // A borrow out of the subtraction means the divisor did not fit: restore.
            if (!div_diff_s[WIDTH]) begin
                acc_next = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Operand latch, accumulator and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {(2*WIDTH){1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            div_mode_r <= 1'b0;
            cnt_r      <= {SHAMT_W{1'b0}};
        end else if (load) begin
            acc_r      <= {{WIDTH{1'b0}}, op_a};
            opnd_r     <= op_b;
            div_mode_r <= is_div;
            cnt_r      <= {SHAMT_W{1'b0}};
        end else if (step) begin
            acc_r      <= acc_next;
            cnt_r      <= cnt_r + {{(SHAMT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_r      <= acc_r;
            cnt_r      <= cnt_r;
        end
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// EX-stage ALU: single-cycle logic/arith/shift ops plus iterative MULTU/DIVU writing HI/LO.
// All outputs are registered; done pulses for one cycle whenever Aluout/zero/hi/lo update.
import alu_pkg::*;

module alu_seq_muldiv #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic              clk,
    input logic              rst_n,
    alu_seq_muldiv_if.slave  bus
);

    logic [1:0]         state_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   aluout_r;
    logic               zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   sc_res_s;
    logic               load_s;
    logic               step_s;
    logic               is_div_s;
    logic               last_s;
    logic [2*WIDTH-1:0] acc_next_s;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.Aluout = aluout_r;
    assign bus.zero   = zero_r;
    assign bus.hi     = hi_r;
    assign bus.lo     = lo_r;

    // Single-cycle result mux; multi-cycle and reserved codes yield zero here.
    always_comb begin
        sc_res_s = {WIDTH{1'b0}};
        case (bus.Aluctl)
            ALU_AND:  sc_res_s = bus.A & bus.B;
            ALU_OR:   sc_res_s = bus.A | bus.B;
            ALU_ADD:  sc_res_s = bus.A + bus.B;
            ALU_SRL:  sc_res_s = bus.B >> bus.shift_amount;
            ALU_SRA:  sc_res_s = $unsigned($signed(bus.B) >>> bus.shift_amount);
            ALU_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            ALU_SUB:  sc_res_s = bus.A - bus.B;
            ALU_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            ALU_SLL:  sc_res_s = bus.B << bus.shift_amount;
            ALU_XOR:  sc_res_s = bus.A ^ bus.B;
            ALU_NOR:  sc_res_s = ~(bus.A | bus.B);
            ALU_MFHI: sc_res_s = hi_r;
            ALU_MFLO: sc_res_s = lo_r;
            default:  sc_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Datapath control: load operands on an accepted MULTU/DIVU, step while iterating.
    always_comb begin
        load_s   = 1'b0;
        is_div_s = 1'b0;
        step_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            load_s   = bus.start && is_multi_cycle(bus.Aluctl);
            is_div_s = (bus.Aluctl == ALU_DIVU);
        end else begin
            step_s   = (state_r == ST_MUL) || (state_r == ST_DIV);
        end
    end

    alu_muldiv_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .step     (step_s),
        .is_div   (is_div_s),
        .op_a     (bus.A),
        .op_b     (bus.B),
        .last     (last_s),
        .acc_next (acc_next_s)
    );

    // FSM and output registers; the final iteration is written straight into HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            aluout_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (load_s) begin
                            state_r <= is_div_s ? ST_DIV : ST_MUL;
                            busy_r  <= 1'b1;
                        end else begin
                            aluout_r <= sc_res_s;
                            zero_r   <= (sc_res_s == {WIDTH{1'b0}});
                            done_r   <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (last_s) begin
                        state_r  <= ST_FIN;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        hi_r     <= acc_next_s[2*WIDTH-1:WIDTH];
                        lo_r     <= acc_next_s[WIDTH-1:0];
                        aluout_r <= acc_next_s[WIDTH-1:0];
                        zero_r   <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed self-checking bench for alu_seq_muldiv (WIDTH=32): single-cycle ops, MULTU/DIVU
// timing and results, HI/LO moves, busy/FIN start rejection, mid-op reset, model-checked sweep.
module tb_alu_seq_muldiv;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_seq_muldiv_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    alu_seq_muldiv #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        bus.start = 1'b0; bus.Aluctl = 4'd0; bus.A = 32'd0; bus.B = 32'd0; bus.shift_amount = 5'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        @(negedge clk);
        bus.start = 1'b1; bus.Aluctl = op; bus.A = a; bus.B = b; bus.shift_amount = sh;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Aluout !== 32'd0 || bus.zero !== 1'b1
            || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_values got busy=%b done=%b alu=%h zero=%b hi=%h lo=%h exp 0 0 0 1 0 0",
                     bus.busy, bus.done, bus.Aluout, bus.zero, bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [5];
        logic [31:0] as  [5];
        logic [31:0] bs  [5];
        logic [4:0]  shs [5];
        logic [31:0] exp [5];
        int dones;
        ops[0] = 4'd2; as[0] = 32'hFFFF_FFFF; bs[0] = 32'd1;          shs[0] = 5'd0; exp[0] = 32'd0;
        ops[1] = 4'd6; as[1] = 32'd5;         bs[1] = 32'd7;          shs[1] = 5'd0; exp[1] = 32'hFFFF_FFFE;
        ops[2] = 4'd7; as[2] = 32'hFFFF_FFFF; bs[2] = 32'd1;          shs[2] = 5'd0; exp[2] = 32'd1;
        ops[3] = 4'd5; as[3] = 32'hFFFF_FFFF; bs[3] = 32'd1;          shs[3] = 5'd0; exp[3] = 32'd0;
        ops[4] = 4'd4; as[4] = 32'd0;         bs[4] = 32'h8000_0000;  shs[4] = 5'd4; exp[4] = 32'hF800_0000;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.Aluctl = ops[0]; bus.A = as[0]; bus.B = bs[0]; bus.shift_amount = shs[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            checks++;
            if (bus.Aluout !== exp[i] || bus.zero !== (exp[i] == 32'd0) || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL b2b_op%0d got alu=%h zero=%b busy=%b exp alu=%h zero=%b busy=0",
                         i, bus.Aluout, bus.zero, bus.busy, exp[i], (exp[i] == 32'd0));
            end
            if (i < 4) begin
                bus.Aluctl = ops[i+1]; bus.A = as[i+1]; bus.B = bs[i+1]; bus.shift_amount = shs[i+1];
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (dones != 5 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_count got dones=%0d trailing_done=%b exp 5 0", dones, bus.done);
        end
    endtask

    task automatic test_logic_ops();
        logic [3:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        logic [4:0]  shs [6];
        logic [31:0] exp [6];
        ops[0] = 4'd0;  as[0] = 32'hFF00_FF00; bs[0] = 32'h0F0F_0F0F; shs[0] = 5'd0;  exp[0] = 32'h0F00_0F00;
        ops[1] = 4'd3;  as[1] = 32'd0;         bs[1] = 32'h8000_0000; shs[1] = 5'd31; exp[1] = 32'd1;
        ops[2] = 4'd10; as[2] = 32'd0;         bs[2] = 32'd1;         shs[2] = 5'd31; exp[2] = 32'h8000_0000;
        ops[3] = 4'd11; as[3] = 32'hF0F0_F0F0; bs[3] = 32'h0FF0_0FF0; shs[3] = 5'd0;  exp[3] = 32'hFF00_FF00;
        ops[4] = 4'd12; as[4] = 32'd0;         bs[4] = 32'd0;         shs[4] = 5'd0;  exp[4] = 32'hFFFF_FFFF;
        ops[5] = 4'd15; as[5] = 32'hFFFF_FFFF; bs[5] = 32'hFFFF_FFFF; shs[5] = 5'd3;  exp[5] = 32'd0;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], shs[i]);
            checks++;
            if (bus.done !== 1'b1 || bus.Aluout !== exp[i] || bus.zero !== (exp[i] == 32'd0)) begin
                failures++;
                $display("FAIL logic_op%0d got done=%b alu=%h zero=%b exp done=1 alu=%h",
                         ops[i], bus.done, bus.Aluout, bus.zero, exp[i]);
            end
        end
    endtask

    task automatic test_multu();
        int n;
        logic ok_busy;
        ok_busy = 1'b1;
        issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        // Start pulses with different operands while busy must be ignored.
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'b1; bus.Aluctl = 4'd2; bus.A = 32'd1; bus.B = 32'd1;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) ok_busy = 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (!ok_busy) begin
            failures++;
            $display("FAIL multu_busy got busy/done not 1/0 during iteration exp busy=1 done=0");
        end
        wait_done(n);
        checks++;
        if (n + 5 != 32) begin
            failures++;
            $display("FAIL multu_latency got %0d cycles after capture exp 32", n + 5);
        end
        checks++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001 || bus.Aluout !== 32'd1
            || bus.busy !== 1'b0 || bus.zero !== 1'b0) begin
            failures++;
            $display("FAIL multu_result got hi=%h lo=%h alu=%h busy=%b exp hi=fffffffe lo=00000001 alu=1 busy=0",
                     bus.hi, bus.lo, bus.Aluout, bus.busy);
        end
        // A start presented in the done cycle is not accepted.
        bus.start = 1'b1; bus.Aluctl = 4'd2; bus.A = 32'd3; bus.B = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.Aluout !== 32'd1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL fin_start_ignored got done=%b alu=%h busy=%b exp done=0 alu=1 busy=0",
                     bus.done, bus.Aluout, bus.busy);
        end
    endtask

    task automatic test_divu();
        int n;
        issue(4'd9, 32'd100, 32'd7, 5'd0);
        wait_done(n);
        checks++;
        if (n != 32 || bus.lo !== 32'd14 || bus.hi !== 32'd2 || bus.Aluout !== 32'd14) begin
            failures++;
            $display("FAIL divu_100_7 got lat=%0d lo=%h hi=%h alu=%h exp lat=32 lo=e hi=2 alu=e",
                     n, bus.lo, bus.hi, bus.Aluout);
        end
        issue(4'd9, 32'd9, 32'd0, 5'd0);
        wait_done(n);
        checks++;
        if (n != 32 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd9 || bus.Aluout !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL divu_by_zero got lat=%0d lo=%h hi=%h alu=%h exp lat=32 lo=ffffffff hi=9",
                     n, bus.lo, bus.hi, bus.Aluout);
        end
    endtask

    task automatic test_mfhi_mflo();
        int n;
        issue(4'd9, 32'd100, 32'd7, 5'd0);
        wait_done(n);
        issue(4'd13, 32'd0, 32'd0, 5'd0);
        checks++;
        if (bus.done !== 1'b1 || bus.Aluout !== 32'd2) begin
            failures++;
            $display("FAIL mfhi got done=%b alu=%h exp done=1 alu=2", bus.done, bus.Aluout);
        end
        issue(4'd14, 32'd0, 32'd0, 5'd0);
        checks++;
        if (bus.done !== 1'b1 || bus.Aluout !== 32'd14) begin
            failures++;
            $display("FAIL mflo got done=%b alu=%h exp done=1 alu=e", bus.done, bus.Aluout);
        end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        issue(4'd8, 32'h1234_5678, 32'd3, 5'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Aluout !== 32'd0 || bus.zero !== 1'b1
            || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_op got busy=%b done=%b alu=%h zero=%b hi=%h lo=%h exp 0 0 0 1 0 0",
                     bus.busy, bus.done, bus.Aluout, bus.zero, bus.hi, bus.lo);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_no_done got late_events=%0d hi=%h lo=%h exp 0 0 0", dones, bus.hi, bus.lo);
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b, exp, m_hi, m_lo;
        logic [4:0]  sh;
        logic [63:0] prod;
        int n, exp_lat;
        do_reset();
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(1, 9));
            sh = 5'($urandom_range(0, 31));
            exp_lat = 0;
            case (op)
                4'd0:  exp = a & b;
                4'd1:  exp = a | b;
                4'd2:  exp = a + b;
                4'd3:  exp = b >> sh;
                4'd4:  exp = $unsigned($signed(b) >>> sh);
                4'd5:  exp = (a < b) ? 32'd1 : 32'd0;
                4'd6:  exp = a - b;
                4'd7:  exp = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'd8: begin
                    prod = {32'd0, a} * {32'd0, b};
                    m_hi = prod[63:32]; m_lo = prod[31:0]; exp = m_lo; exp_lat = 32;
                end
                4'd9: begin
                    if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                    else begin m_lo = a / b; m_hi = a % b; end
                    exp = m_lo; exp_lat = 32;
                end
                4'd10: exp = b << sh;
                4'd11: exp = a ^ b;
                4'd12: exp = ~(a | b);
                4'd13: exp = m_hi;
                4'd14: exp = m_lo;
                default: exp = 32'd0;
            endcase
            issue(op, a, b, sh);
            wait_done(n);
            checks++;
            if (n != exp_lat || bus.Aluout !== exp || bus.zero !== (exp == 32'd0)
                || bus.hi !== m_hi || bus.lo !== m_lo) begin
                failures++;
                $display("FAIL random_%0d op=%0d a=%h b=%h sh=%0d got lat=%0d alu=%h hi=%h lo=%h exp lat=%0d alu=%h hi=%h lo=%h",
                         i, op, a, b, sh, n, bus.Aluout, bus.hi, bus.lo, exp_lat, exp, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_back_to_back();
        test_logic_ops();
        test_multu();
        test_divu();
        test_mfhi_mflo();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
